// File: rtl/acumulador_pkg.sv
// Shared types for the bit-serial sign-magnitude accumulator: FSM states and
// the width of the serial bit index.
package acumulador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERIAL = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A single-bit index still needs one flop.
    function automatic int idx_w(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/sumador_bit_serial.sv
// One-bit full adder cell.
// The same cell serves both the magnitude add/subtract pass and the negate pass.
module sumador_bit_serial (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/acumulador_serial_sm.sv
// Bit-serial sign-magnitude accumulator: one full-adder cell, LSB first, plus
// a serial two's-complement pass when the magnitude subtraction borrows.
// Optional macro SERIAL_SATURATE_EN: an add overflow commits all ones instead of wrapping.
module acumulador_serial_sm
    import acumulador_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_pos,
    input  logic [BITS-1:0] in_mag,
    output logic            acc_pos,
    output logic [BITS-1:0] acc_mag,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    localparam int IW = idx_w(BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(BITS - 1);

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            op_sub_q;
    logic            new_pos_q;
    logic [BITS-1:0] opmag_q;
    logic [BITS-1:0] res_q;
    logic [BITS-1:0] acc_mag_q;
    logic            acc_pos_q;
    logic            done_q;
    logic            ovf_q;

    logic            fa_a;
    logic            fa_b;
    logic            fa_s;
    logic            fa_cout;
    logic [BITS-1:0] res_d;

    // SERIAL adds acc + (op or ~op); NEGATE feeds ~r with b=0 so carry-in does the +1.
    always_comb begin
        fa_a = 1'b0;
        fa_b = 1'b0;
        if (state_q == NEGATE) begin
            fa_a = ~res_q[0];
        end else begin
            fa_a = acc_mag_q[idx_q];
            fa_b = opmag_q[0] ^ op_sub_q;
        end
    end

    sumador_bit_serial u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Result enters at the MSB, so after BITS shifts it is LSB-aligned.
    assign res_d = {fa_s, res_q[BITS-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            op_sub_q  <= 1'b0;
            new_pos_q <= 1'b1;
            opmag_q   <= '0;
            res_q     <= '0;
            acc_mag_q <= '0;
            acc_pos_q <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        acc_pos_q <= 1'b1;
                        acc_mag_q <= '0;
                        ovf_q     <= 1'b0;
                    end else if (in_valid) begin
                        opmag_q   <= in_mag;
                        op_sub_q  <= (in_pos != acc_pos_q);
                        carry_q   <= (in_pos != acc_pos_q);
                        new_pos_q <= acc_pos_q;
                        idx_q     <= '0;
                        state_q   <= SERIAL;
                    end
                end
                SERIAL: begin
                    carry_q <= fa_cout;
                    res_q   <= res_d;
                    opmag_q <= opmag_q >> 1;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        if (!op_sub_q) begin
                            state_q <= DONE;
                            if (fa_cout) begin
                                ovf_q <= 1'b1;
`ifdef SERIAL_SATURATE_EN
                                res_q <= '1;
`else
                                res_q <= res_d;
`endif
                            end
                        end else if (fa_cout) begin
                            state_q <= DONE;
                        end else begin
                            // Borrow: magnitude is in two's complement and the sign flips.
                            new_pos_q <= ~new_pos_q;
                            carry_q   <= 1'b1;
                            state_q   <= NEGATE;
                        end
                    end
                end
                NEGATE: begin
                    carry_q <= fa_cout;
                    res_q   <= res_d;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    acc_mag_q <= res_q;
                    acc_pos_q <= (res_q == '0) ? 1'b1 : new_pos_q;
                    done_q    <= 1'b1;
                    carry_q   <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake: an operand transfers on a rising edge where in_valid & in_ready;
    // the source holds in_valid/in_pos/in_mag stable until then.
    assign in_ready = (state_q == IDLE) & ~clear;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign acc_pos  = acc_pos_q;
    assign acc_mag  = acc_mag_q;

endmodule
